// File: rtl/dispatch_if.sv
// dispatch_if: fetch-side and instruction-queue-side signals of the dispatch buffer
interface dispatch_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
);
   localparam int CW = $clog2(DEPTH + 1);
   logic [0:1]       fetchValid;
   logic [TAG_W-1:0] fetchTag0;
   logic [TAG_W-1:0] fetchTag1;
   logic             fetchReady;
   logic [0:2]       valid;
   logic [0:2]       flush;
   logic [0:1]       iqLoads;
   logic [TAG_W-1:0] dispTag0;
   logic [TAG_W-1:0] dispTag1;
   logic [CW-1:0]    count;
   modport master (
      output fetchValid, fetchTag0, fetchTag1, valid, flush,
      input  fetchReady, iqLoads, dispTag0, dispTag1, count
   );
   modport slave (
      input  fetchValid, fetchTag0, fetchTag1, valid, flush,
      output fetchReady, iqLoads, dispTag0, dispTag1, count
   );
endinterface

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: two-wide in-order circular tag FIFO feeding the 3-entry instruction queue
module dispatch_buffer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input logic       clock,
   input logic       reset,
   dispatch_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [TAG_W-1:0] tags [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic [CW-1:0]    cnt;
   logic [1:0]       free;
   logic [1:0]       pops;
   logic [1:0]       pushes;
   logic             anyFlush;
   logic             push0;
   logic             push1;
   // dispatch from free queue slots, fetch acceptance on pre-pop count, push/pop accounting
   always_comb begin
      anyFlush       = |bus.flush;
      free           = 2'(!bus.valid[0]) + 2'(!bus.valid[1]) + 2'(!bus.valid[2]);
      bus.iqLoads[0] = ~reset & ~anyFlush & (cnt >= CW'(1)) & (free >= 2'd1);
      bus.iqLoads[1] = ~reset & ~anyFlush & (cnt >= CW'(2)) & (free >= 2'd2);
      bus.fetchReady = ~reset & (cnt <= CW'(DEPTH - 2));
      push0          = bus.fetchReady & ~anyFlush & bus.fetchValid[0];
      push1          = push0 & bus.fetchValid[1];
      pops           = 2'(bus.iqLoads[0]) + 2'(bus.iqLoads[1]);
      pushes         = 2'(push0) + 2'(push1);
      bus.dispTag0   = tags[rdPtr];
      bus.dispTag1   = tags[PW'(rdPtr + 1'b1)];
      bus.count      = cnt;
   end
   // tag storage: lane 0 lands at wrPtr, lane 1 right behind it
   always_ff @(posedge clock) begin
      if (push0) tags[wrPtr] <= bus.fetchTag0;
      if (push1) tags[PW'(wrPtr + 1'b1)] <= bus.fetchTag1;
   end
   // pointers and occupancy; reset and flush both empty the buffer
   always_ff @(posedge clock) begin
      if (reset || anyFlush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         cnt   <= '0;
      end else begin
         rdPtr <= rdPtr + PW'(pops);
         wrPtr <= wrPtr + PW'(pushes);
         cnt   <= cnt + CW'(pushes) - CW'(pops);
      end
   end
   // structural invariants of the circular buffer and in-order dispatch
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (cnt <= CW'(DEPTH));
         assert (bus.iqLoads != 2'b01);
         assert (wrPtr == PW'(rdPtr + PW'(cnt)));
      end
   end
endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: scoreboard bench with a queue-based reference model of the dispatch buffer
module tb_dispatch_buffer;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   dispatch_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
   dispatch_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clock(clock), .reset(reset), .bus(bus));
   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;
   int exp_n = 0;
   bit exp_ready = 1'b0;
   bit active = 1'b0;
   int exp_q [$];
   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   task automatic step(input bit r, input logic [0:1] fv, input int t0, input int t1,
                       input logic [0:2] vl, input logic [0:2] fl);
      int free;
      @(posedge clock);
      #1;
      reset          = r;
      bus.fetchValid = fv;
      bus.fetchTag0  = TAG_W'(t0);
      bus.fetchTag1  = TAG_W'(t1);
      bus.valid      = vl;
      bus.flush      = fl;
      free      = 3 - (int'(vl[0]) + int'(vl[1]) + int'(vl[2]));
      exp_cnt   = exp_q.size();
      exp_ready = !r && (DEPTH - exp_cnt >= 2);
      exp_n     = (r || fl != 3'b000) ? 0 : (exp_cnt < free ? exp_cnt : free);
      if (exp_n > 2) exp_n = 2;
      if (r || fl != 3'b000) exp_q.delete();
      else if (exp_ready && fv[0]) begin
         exp_q.push_back(t0 % (1 << TAG_W));
         if (fv[1]) exp_q.push_back(t1 % (1 << TAG_W));
      end
      active = 1'b1;
   endtask
   always @(negedge clock) begin
      if (active) begin
         check("fetchReady", int'(bus.fetchReady), int'(exp_ready));
         check("count", int'(bus.count), exp_cnt);
         check("iqLoads", int'(bus.iqLoads), exp_n == 0 ? 0 : exp_n == 1 ? 2 : 3);
         if (bus.iqLoads[0]) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL dispTag0: dispatched %0d with nothing expected", bus.dispTag0);
            end else check("dispTag0", int'(bus.dispTag0), exp_q.pop_front());
         end
         if (bus.iqLoads[1]) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL dispTag1: dispatched %0d with nothing expected", bus.dispTag1);
            end else check("dispTag1", int'(bus.dispTag1), exp_q.pop_front());
         end
      end
   end
   initial begin
      int k;
      bus.fetchValid = '0;
      bus.fetchTag0  = '0;
      bus.fetchTag1  = '0;
      bus.valid      = '0;
      bus.flush      = '0;
      repeat (2) @(posedge clock);
      step(1, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b11, 'h11, 'h22, 3'b000, 3'b000);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b11, 1, 2, 3'b111, 3'b000);
      step(0, 2'b10, 3, 0, 3'b111, 3'b000);
      step(0, 2'b00, 0, 0, 3'b110, 3'b000);
      step(0, 2'b00, 0, 0, 3'b111, 3'b000);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      for (int i = 0; i < 4; i++) step(0, 2'b11, 10 + 2 * i, 11 + 2 * i, 3'b111, 3'b000);
      step(0, 2'b01, 30, 31, 3'b111, 3'b000);
      repeat (3) step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b11, 4, 5, 3'b111, 3'b000);
      step(0, 2'b10, 6, 0, 3'b111, 3'b000);
      step(0, 2'b11, 7, 8, 3'b000, 3'b010);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      k = 0;
      for (int i = 0; i < 20;) begin
         step(0, 2'b11, i, i + 1, (k % 2) != 0 ? 3'b100 : 3'b000, 3'b000);
         if (exp_ready) i += 2;
         k++;
      end
      repeat (3) step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      step(0, 2'b11, 40, 41, 3'b111, 3'b000);
      step(1, 2'b11, 42, 43, 3'b000, 3'b000);
      step(0, 2'b11, 'h2a, 'h2b, 3'b000, 3'b000);
      step(0, 2'b00, 0, 0, 3'b000, 3'b000);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 19) == 0 ? 3'($urandom_range(1, 7)) : 3'b000);
      end
      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
